capture_readout: RTL and testbench

Downstream stage of the logic-capture engine. After a capture finishes, it reads the recorded samples back out of the shared 8-bit sample BRAM over an address range supplied by software. It frames the samples as a byte stream (sync, length, data, checksum) and hands them one byte at a time to the UART transmitter over a valid/ready handshake. It owns the BRAM read port; the capture engine owns the write port.

---
 rtl/capture_pkg.sv | 23 ++
 rtl/rising_edge_detect.sv | 18 +
 rtl/capture_readout.sv | 155 +++++++++++++++
 tb/tb_capture_readout.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared types and register bit positions for the logic-capture blocks
// Contents: FSM state enum, default sync byte, control/status bit positions, header byte helper.
package capture_pkg;

   typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, SEND, CSUM, DONE} state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int STAT_BUSY     = 0;
   localparam int STAT_DONE     = 1;
   localparam int STAT_ADDR_LSB = 2;
   localparam int STAT_ADDR_MSB = 19;
   localparam int STAT_ABORTED  = 20;

   // Header byte idx of a frame: sync, then the length big-endian in three bytes.
   function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] len,
                                           input logic [7:0] sync);
      return idx == 2'd0 ? sync : idx == 2'd1 ? len[23:16] : idx == 2'd2 ? len[15:8] : len[7:0];
   endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: 1-bit rising-edge detector against a registered copy of the input
// Ports: clk, resetn (async active-low), d (level input), rise (high while d=1 and previous sample was 0).
module rising_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) prev <= 1'b0;
      else         prev <= d;

   assign rise = d & ~prev;

endmodule

// File: rtl/capture_readout.sv
// capture_readout: reads a BRAM address range and streams it as a framed byte stream
// Ports: clk, resetn (async active-low); control/config0/config1 in, status out (software regs);
//        en/address out, datain in (BRAM read port); tx_data/tx_valid out, tx_ready in (transmitter).
// Frame: SYNC_BYTE, 3-byte big-endian length, data bytes, XOR checksum of the data bytes.
module capture_readout
   import capture_pkg::*;
#(
   parameter int         ADDR_W    = 18,
   parameter int         RD_LAT    = 1,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       control,
   input  logic [31:0]       config0,
   input  logic [31:0]       config1,
   output logic [31:0]       status,
   output logic              en,
   output logic [ADDR_W-1:0] address,
   input  logic [7:0]        datain,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int LEN_W = ADDR_W + 1;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  len;
   logic [LEN_W-1:0]  remaining;
   logic [7:0]        csum;
   logic [1:0]        hdr_idx;
   logic [1:0]        wcnt;
   logic              busy;
   logic              done;
   logic              aborted;
   logic              start_rise;
   logic              abort;
   logic              xfer;
   logic [ADDR_W-1:0] diff;
   logic [LEN_W-1:0]  len_in;
   logic              unused_bits;

   rising_edge_detect u_start (
      .clk    (clk),
      .resetn (resetn),
      .d      (control[CTRL_START]),
      .rise   (start_rise)
   );

   assign abort       = control[CTRL_ABORT];
   assign xfer        = tx_valid & tx_ready;
   assign diff        = config1[ADDR_W-1:0] - config0[ADDR_W-1:0];
   assign len_in      = LEN_W'(diff) + LEN_W'(1);
   assign unused_bits = ^{control[31:2], config0[31:ADDR_W], config1[31:ADDR_W]};

   always_comb begin
      status                            = '0;
      status[STAT_BUSY]                 = busy;
      status[STAT_DONE]                 = done;
      status[STAT_ADDR_LSB +: ADDR_W]   = ptr;
      status[STAT_ABORTED]              = aborted;
   end

   // en is raised on entry to FETCH, so it is high exactly during the FETCH cycle;
   // data then arrives RD_LAT cycles later and is captured on the last WAIT cycle.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state     <= IDLE;
         ptr       <= '0;
         len       <= '0;
         remaining <= '0;
         csum      <= '0;
         hdr_idx   <= '0;
         wcnt      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         en        <= 1'b0;
         address   <= '0;
         tx_data   <= '0;
         tx_valid  <= 1'b0;
      end else if (abort && state != IDLE) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         en       <= 1'b0;
         busy     <= 1'b0;
         aborted  <= 1'b1;
      end else
         case (state)
            IDLE:
               if (start_rise && !abort) begin
                  ptr       <= config0[ADDR_W-1:0];
                  len       <= len_in;
                  remaining <= len_in;
                  csum      <= '0;
                  hdr_idx   <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  aborted   <= 1'b0;
                  tx_data   <= SYNC_BYTE;
                  tx_valid  <= 1'b1;
                  state     <= HDR;
               end
            HDR:
               if (xfer) begin
                  hdr_idx <= hdr_idx + 2'd1;
                  if (hdr_idx == 2'd3) begin
                     tx_valid <= 1'b0;
                     en       <= 1'b1;
                     address  <= ptr;
                     state    <= FETCH;
                  end else
                     tx_data <= hdr_byte(hdr_idx + 2'd1, 24'(len), SYNC_BYTE);
               end
            FETCH: begin
               en    <= 1'b0;
               wcnt  <= 2'd1;
               state <= WAIT;
            end
            WAIT:
               if (wcnt == 2'(RD_LAT)) begin
                  tx_data  <= datain;
                  tx_valid <= 1'b1;
                  state    <= SEND;
               end else
                  wcnt <= wcnt + 2'd1;
            SEND:
               if (xfer) begin
                  csum      <= csum ^ tx_data;
                  ptr       <= ptr + ADDR_W'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     tx_data <= csum ^ tx_data;
                     state   <= CSUM;
                  end else begin
                     tx_valid <= 1'b0;
                     en       <= 1'b1;
                     address  <= ptr + ADDR_W'(1);
                     state    <= FETCH;
                  end
               end
            CSUM:
               if (xfer) begin
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: scoreboard bench for capture_readout with RD_LAT=1 (dut 0) and RD_LAT=2 (dut 1)
module tb_capture_readout;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] control [2];
   logic [31:0] config0 [2];
   logic [31:0] config1 [2];
   logic [31:0] status [2];
   logic        en [2];
   logic [17:0] address [2];
   logic [7:0]  datain [2];
   logic [7:0]  tx_data [2];
   logic        tx_valid [2];
   logic        tx_ready [2];
   logic        rnd [2];

   logic [7:0]  mem [0:262143];
   logic [7:0]  r1 [2];
   logic [7:0]  r2;

   logic [7:0]  q0 [$];
   logic [7:0]  q1 [$];
   logic [17:0] a0 [$];
   logic [17:0] a1 [$];

   int checks = 0;
   int errors = 0;

   logic [7:0] s1 [8] = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
   logic [7:0] s2 [9] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
   logic [7:0] s4 [6] = '{8'hA5, 8'h00, 8'h00, 8'h08, 8'h80, 8'h81};
   logic [7:0] s6 [6] = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h5A};
   logic [7:0] sf [4] = '{8'hA5, 8'h04, 8'h00, 8'h00};

   always #5 clk = ~clk;

   capture_readout #(.RD_LAT(1)) dut0 (
      .clk(clk), .resetn(resetn), .control(control[0]), .config0(config0[0]), .config1(config1[0]),
      .status(status[0]), .en(en[0]), .address(address[0]), .datain(datain[0]),
      .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0])
   );

   capture_readout #(.RD_LAT(2)) dut1 (
      .clk(clk), .resetn(resetn), .control(control[1]), .config0(config0[1]), .config1(config1[1]),
      .status(status[1]), .en(en[1]), .address(address[1]), .datain(datain[1]),
      .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1])
   );

   // BRAM models: output is junk unless a read was enabled, so a mistimed capture shows up.
   always @(posedge clk) begin
      r1[0] <= en[0] ? mem[address[0]] : 8'hEE;
      r1[1] <= en[1] ? mem[address[1]] : 8'hEE;
      r2    <= r1[1];
   end
   assign datain[0] = r1[0];
   assign datain[1] = r2;

   initial forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) tx_ready[d] = rnd[d] ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   function automatic int qsize(input int d);
      return d == 0 ? q0.size() : q1.size();
   endfunction

   function automatic int asize(input int d);
      return d == 0 ? a0.size() : a1.size();
   endfunction

   task automatic push_b(input int d, input logic [7:0] b);
      if (d == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   task automatic push_a(input int d, input logic [17:0] a);
      if (d == 0) a0.push_back(a);
      else        a1.push_back(a);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitor: pops expected bytes/addresses on every transfer/read and checks hold-stability.
   initial begin : mon
      logic       pv [2];
      logic [7:0] pd [2];
      logic [7:0] e;
      logic [17:0] ea;
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      pd[0] = '0;
      pd[1] = '0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (pv[d] && !control[d][1]) begin
               checks++;
               if (tx_valid[d] !== 1'b1 || tx_data[d] !== pd[d]) begin
                  errors++;
                  $display("FAIL hold%0d: valid %b data %h, required valid 1 data %h", d, tx_valid[d], tx_data[d], pd[d]);
               end
            end
            if (tx_valid[d] && tx_ready[d]) begin
               checks++;
               if (qsize(d) == 0) begin
                  errors++;
                  $display("FAIL byte%0d: unexpected byte %h, required none", d, tx_data[d]);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  if (tx_data[d] !== e) begin
                     errors++;
                     $display("FAIL byte%0d: got %h, required %h", d, tx_data[d], e);
                  end
               end
            end
            if (en[d]) begin
               checks++;
               if (asize(d) == 0) begin
                  errors++;
                  $display("FAIL addr%0d: unexpected read %h, required none", d, address[d]);
               end else begin
                  if (d == 0) ea = a0.pop_front();
                  else        ea = a1.pop_front();
                  if (address[d] !== ea) begin
                     errors++;
                     $display("FAIL addr%0d: got %h, required %h", d, address[d], ea);
                  end
               end
            end
            pv[d] = tx_valid[d] && !tx_ready[d];
            pd[d] = tx_data[d];
         end
      end
   end

   task automatic cfg(input int d, input logic [17:0] first, input logic [17:0] last, input int n);
      config0[d] = {14'h1555, first};
      config1[d] = {14'h2AAA, last};
      for (int i = 0; i < n; i++) push_a(d, 18'(first + 18'(i)));
   endtask

   task automatic start(input int d, input logic hold);
      @(negedge clk);
      #1 control[d][0] = 1'b1;
      @(negedge clk);
      chk($sformatf("start_lat%0d", d), {tx_valid[d], status[d][0], tx_data[d]}, {1'b1, 1'b1, 8'hA5});
      #1 if (!hold) control[d][0] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!status[d][1] && k < 2000);
      chk($sformatf("done%0d", d), {k < 2000, status[d][20], status[d][1], status[d][0]}, 4'b1010);
      chk($sformatf("drain%0d", d), qsize(d), 0);
      chk($sformatf("reads%0d", d), asize(d), 0);
   endtask

   task automatic wait_empty(input int d);
      int k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (qsize(d) != 0 && k < 2000);
      chk($sformatf("empty%0d", d), qsize(d), 0);
   endtask

   task automatic abort_now(input int d, input logic [17:0] next_addr);
      @(negedge clk);
      #1 control[d][1] = 1'b1;
      @(negedge clk);
      chk($sformatf("abort%0d", d), {tx_valid[d], en[d], status[d][20], status[d][1], status[d][0]}, 5'b00100);
      chk($sformatf("abort_ptr%0d", d), status[d][19:2], next_addr);
      chk($sformatf("abort_reads%0d", d), asize(d), 0);
      #1 control[d][1] = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         control[d] = '0;
         config0[d] = '0;
         config1[d] = '0;
         rnd[d]     = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_status%0d", d), status[d], 32'h0);
         chk($sformatf("rst_outs%0d", d), {en[d], address[d], tx_data[d], tx_valid[d]}, '0);
      end
      resetn = 1'b1;

      mem[18'h00010] = 8'h11; mem[18'h00011] = 8'h22; mem[18'h00012] = 8'h33;
      mem[18'h3FFFE] = 8'h01; mem[18'h3FFFF] = 8'h02; mem[18'h00000] = 8'h03; mem[18'h00001] = 8'h04;
      mem[18'h0002A] = 8'h5A;
      for (int i = 0; i < 8; i++) mem[18'h100 + i] = 8'h80 + 8'(i);

      // basic three-byte frame
      foreach (s1[i]) push_b(0, s1[i]);
      cfg(0, 18'h00010, 18'h00012, 3);
      start(0, 1'b0);
      wait_done(0);
      chk("ptr_after0", status[0][19:2], 18'h00013);

      // wrap across the top of memory
      foreach (s2[i]) push_b(0, s2[i]);
      cfg(0, 18'h3FFFE, 18'h00001, 4);
      start(0, 1'b0);
      wait_done(0);
      chk("ptr_wrap0", status[0][19:2], 18'h00002);

      // single byte
      foreach (s6[i]) push_b(0, s6[i]);
      cfg(0, 18'h0002A, 18'h0002A, 1);
      start(0, 1'b0);
      wait_done(0);

      // backpressure on both read latencies
      rnd[0] = 1'b1;
      rnd[1] = 1'b1;
      foreach (s2[i]) push_b(0, s2[i]);
      cfg(0, 18'h3FFFE, 18'h00001, 4);
      start(0, 1'b0);
      wait_done(0);
      foreach (s2[i]) push_b(1, s2[i]);
      cfg(1, 18'h3FFFE, 18'h00001, 4);
      start(1, 1'b0);
      wait_done(1);
      foreach (s1[i]) push_b(1, s1[i]);
      cfg(1, 18'h00010, 18'h00012, 3);
      start(1, 1'b0);
      wait_done(1);
      rnd[0] = 1'b0;
      rnd[1] = 1'b0;
      foreach (s1[i]) push_b(1, s1[i]);
      cfg(1, 18'h00010, 18'h00012, 3);
      start(1, 1'b0);
      wait_done(1);

      // abort after the second data byte, then a clean frame
      foreach (s4[i]) push_b(0, s4[i]);
      cfg(0, 18'h00100, 18'h00107, 3);
      start(0, 1'b0);
      wait_empty(0);
      abort_now(0, 18'h00102);
      repeat (5) @(negedge clk);
      foreach (s6[i]) push_b(0, s6[i]);
      cfg(0, 18'h0002A, 18'h0002A, 1);
      start(0, 1'b0);
      wait_done(0);

      // full-memory length header, aborted once the header is out
      foreach (sf[i]) push_b(0, sf[i]);
      cfg(0, 18'h00050, 18'h0004F, 1);
      start(0, 1'b0);
      wait_empty(0);
      abort_now(0, 18'h00050);

      // start and abort together: no frame
      @(negedge clk);
      #1 control[0] = 32'h3;
      @(negedge clk);
      chk("start_abort", {tx_valid[0], status[0][0]}, 2'b00);
      #1 control[0] = 32'h0;
      repeat (10) @(negedge clk);
      chk("start_abort_idle", {tx_valid[0], status[0][0]}, 2'b00);

      // held start gives one frame; an edge while busy is ignored
      foreach (s1[i]) push_b(0, s1[i]);
      cfg(0, 18'h00010, 18'h00012, 3);
      start(0, 1'b1);
      repeat (6) @(negedge clk);
      #1 control[0][0] = 1'b0;
      @(negedge clk);
      #1 control[0][0] = 1'b1;
      wait_done(0);
      repeat (40) @(negedge clk);
      chk("one_frame", {tx_valid[0], status[0][1], status[0][0]}, 3'b010);
      #1 control[0] = 32'h0;
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
